fog_loop_core_v2: RTL
=====================

// Module: fog_loop_core_v2
// PURPOSE
//  Parametrised single-clock closed-loop FOG engine. Replaces the four-instance
//  mod/err/step/ramp chain. Generates a square-wave bias modulation and
//  demodulates the ADC samples against it. Integrates the error into a feedback
//  step, then accumulates the step into a wrapping phase ramp. Drives
//  ramp+modulation to the DAC. Widths and averaging depth are parameters.
// PARAMETERS
//  ADC_W    14  ADC sample width (signed two's complement)
//  DAC_W    16  DAC output width
//  ACC_W    32  width of the error, step and ramp datapaths
//  AVG_MAX  8   max log2 of samples averaged per half-period (i_avg_sel clamped to this)
// PORTS
//  i_clk         in   1        sole clock (DAC domain)
//  i_rst         in   1        reset, asynchronous, active-high
//  i_adc         in   ADC_W    signed ADC sample, already synchronous to i_clk
//  i_half_cnt    in   32       modulation half-period in cycles (min 2)
//  i_wait_cnt    in   32       settle cycles after each modulation edge before averaging
//  i_avg_sel     in   4        log2 of the sample count averaged per half-period
//  i_amp_h       in   DAC_W    signed modulation level, H half
//  i_amp_l       in   DAC_W    signed modulation level, L half
//  i_polarity    in   1        1 = invert error sign
//  i_err_offset  in   ACC_W    signed offset subtracted from the error
//  i_fb_on       in   1        1 = closed loop, 0 = step forced to i_const_step
//  i_const_step  in   ACC_W    signed open-loop step
//  i_gain_step   in   5        right-shift applied to the error before step integration
//  i_gain_ramp   in   5        right-shift applied to the step before ramp accumulation
//  o_dac         out  DAC_W    registered ramp[ACC_W-1 -: DAC_W] + modulation, wrapping add
//  o_err         out  ACC_W    signed demodulated error
//  o_err_vld     out  1        1-cycle pulse when o_err is updated
//  o_step        out  ACC_W    signed feedback step
//  o_ramp        out  ACC_W    phase ramp accumulator; wraps modulo 2^ACC_W (2pi)
//  o_cfg_err     out  1        sticky: wait+2^avg_sel > half_cnt seen; cleared by the next good period
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, mod phase H, half counter 0.
//  - First post-reset cycle moves to WAIT.
//  Config sampling:
//  - All i_* config inputs are sampled on the first cycle of each H half.
//  - Held for the whole period (H+L); mid-period changes have no effect.
//  Half counter:
//  - Counts 0..half_cnt-1; the last cycle toggles the phase and restarts WAIT.
//  - half_cnt<2 is treated as 2.
//  FSM per half: IDLE->WAIT (wait_cnt cycles; 0 = skip)->ACCUM (2^avg_sel samples)->HOLD until the half ends.
//  - Sum width is ADC_W+AVG_MAX+1, signed; sumH and sumL are kept separately.
//  - If the half ends in WAIT or ACCUM: the period is invalid, o_cfg_err=1,
//    no o_err_vld, and step/ramp are frozen for that period.
//  Error, with T = last cycle of the L half:
//  - T+1: o_err = ((sumH-sumL) >>> avg_sel) * (pol?-1:1) - err_offset,
//    sign-extended to ACC_W; o_err_vld=1.
//  Step update at T+2:
//  - fb_on=1: step += o_err >>> gain_step.
//  - fb_on=0: step = const_step.
//  - 1->0 transition: step loads const_step immediately.
//  - 0->1 transition: integration starts from const_step.
//  Ramp at T+3: ramp += step >>> gain_ramp (ACC_W wrap = phase reset); o_dac also updates every cycle.
//  Modulation term: amp_h in the H half, amp_l in the L half. o_dac is registered, 1 cycle after the phase change.
//  Arithmetic: all shifts arithmetic; step overflow wraps unless the macro is set; ramp always wraps.
//  Reset mid-period discards partial sums; no stale o_err_vld after deassertion.
// CONFIGURATION
//  FOG_STEP_SAT_EN defined:
//  - Step integration saturates at +/-(2^(ACC_W-1)-1).
//  - A saturated update also sets o_cfg_err for that period.
//  FOG_STEP_SAT_EN undefined: step wraps two's complement; no saturation logic is built.
// TESTING
//  1) half_cnt=8, wait=2, avg_sel=2, amp_h=100, amp_l=-100, adc const 0 -> o_dac alternates 100/-100 every 8 cycles; o_err=0 each 16 cycles.
//  2) adc=+40 in H, -40 in L, pol=0, offset=0 -> o_err=80; pol=1 -> -80; offset=5, pol=0 -> 75.
//  3) fb_on=1, gain_step=0, err constant 80 -> o_step 80,160,240 on successive periods; fb_on=0, const_step=7 -> o_step=7 next period.
//  4) const_step=2^30, gain_ramp=0 -> o_ramp 2^30, 2^31, 3*2^30, 0 (wrap).
//  5) half_cnt=8, wait=6, avg_sel=2 -> o_cfg_err=1, no o_err_vld, step/ramp frozen; fix wait=1 -> cleared next period.
//  6) Step near max with err>0: FOG_STEP_SAT_EN -> holds 2^31-1; undefined -> wraps negative. Then i_rst pulse mid-ACCUM -> all outputs 0.

Source files
------------

// File: rtl/fog_loop_core_v2.sv
// fog_loop_core_v2: closed-loop FOG bias modulation, demodulation and ramp.
// Optional FOG_STEP_SAT_EN: saturate the feedback step integrator.
module fog_loop_core_v2 #(
  parameter int ADC_W   = 14,
  parameter int DAC_W   = 16,
  parameter int ACC_W   = 32,
  parameter int AVG_MAX = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic signed [ADC_W-1:0] i_adc,
  input  logic [31:0]             i_half_cnt,
  input  logic [31:0]             i_wait_cnt,
  input  logic [3:0]              i_avg_sel,
  input  logic signed [DAC_W-1:0] i_amp_h,
  input  logic signed [DAC_W-1:0] i_amp_l,
  input  logic                    i_polarity,
  input  logic signed [ACC_W-1:0] i_err_offset,
  input  logic                    i_fb_on,
  input  logic signed [ACC_W-1:0] i_const_step,
  input  logic [4:0]              i_gain_step,
  input  logic [4:0]              i_gain_ramp,
  output logic [DAC_W-1:0]        o_dac,
  output logic signed [ACC_W-1:0] o_err,
  output logic                    o_err_vld,
  output logic signed [ACC_W-1:0] o_step,
  output logic [ACC_W-1:0]        o_ramp,
  output logic                    o_cfg_err
);
  localparam int SW = ADC_W + AVG_MAX + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ACC, S_HOLD
  } st_e;

  logic [31:0]             half_q, wait_q, hcnt_q;
  logic [3:0]              avg_q;
  logic signed [DAC_W-1:0] amph_q, ampl_q;
  logic                    pol_q, fb_q;
  logic signed [ACC_W-1:0] off_q, cs_q;
  logic [4:0]              gs_q, gr_q;
  logic                    ph_q, run_q;
  logic signed [SW-1:0]    sum_q, sumh_q;
  logic signed [ACC_W-1:0] err_q, step_q;
  logic [ACC_W-1:0]        ramp_q;
  logic [DAC_W-1:0]        dac_q;
  logic                    err_vld_q, stp_vld_q;
  logic                    cfg_err_q;
  logic                    p_fb_q;
  logic signed [ACC_W-1:0] p_cs_q;
  logic [4:0]              p_gs_q, p_gr_q;

  logic                    first_h, last, end_per;
  logic [3:0]              avg_cl, c_avg;
  logic [31:0]             c_half, c_wait, half_eff;
  logic signed [DAC_W-1:0] c_amph, c_ampl, mod;
  logic                    c_pol, c_fb;
  logic signed [ACC_W-1:0] c_off, c_cs;
  logic [4:0]              c_gs, c_gr;
  logic [32:0]             nsmp, w33, pos, acc_end;
  logic                    in_acc, period_ok, acc_en;
  st_e                     st;
  logic signed [SW-1:0]    adc_x, sum_base, sum_d;
  logic signed [SW:0]      diff, dsh;
  logic signed [ACC_W-1:0] dext, err_d;
  logic signed [ACC_W-1:0] inc, rinc, step_nx;

  assign first_h  = !ph_q && (hcnt_q == '0);
  assign avg_cl   = (i_avg_sel > 4'(AVG_MAX))
                  ? 4'(AVG_MAX) : i_avg_sel;
  assign c_half   = first_h ? i_half_cnt   : half_q;
  assign c_wait   = first_h ? i_wait_cnt   : wait_q;
  assign c_avg    = first_h ? avg_cl       : avg_q;
  assign c_amph   = first_h ? i_amp_h      : amph_q;
  assign c_ampl   = first_h ? i_amp_l      : ampl_q;
  assign c_pol    = first_h ? i_polarity   : pol_q;
  assign c_off    = first_h ? i_err_offset : off_q;
  assign c_fb     = first_h ? i_fb_on      : fb_q;
  assign c_cs     = first_h ? i_const_step : cs_q;
  assign c_gs     = first_h ? i_gain_step  : gs_q;
  assign c_gr     = first_h ? i_gain_ramp  : gr_q;

  assign half_eff = (c_half < 32'd2) ? 32'd2 : c_half;
  assign last     = (hcnt_q == half_eff - 32'd1);
  assign end_per  = last && ph_q;

  assign nsmp      = 33'd1 << c_avg;
  assign w33       = {1'b0, c_wait};
  assign pos       = {1'b0, hcnt_q};
  assign acc_end   = w33 + nsmp;
  assign in_acc    = (pos >= w33) && (pos < acc_end);
  assign period_ok = (acc_end <= {1'b0, half_eff});

  // Per-half sequence decoded from the position within the half.
  always_comb begin
    st = S_HOLD;
    if (!run_q)             st = S_IDLE;
    else if (pos < w33)     st = S_WAIT;
    else if (pos < acc_end) st = S_ACC;
  end

  assign acc_en = (st == S_ACC)
               || ((st == S_IDLE) && in_acc);

  assign adc_x    = {{(SW-ADC_W){i_adc[ADC_W-1]}}, i_adc};
  assign sum_base = (hcnt_q == '0) ? '0 : sum_q;
  assign sum_d    = sum_base + (acc_en ? adc_x : '0);

  assign diff  = {sumh_q[SW-1], sumh_q}
               - {sum_d[SW-1], sum_d};
  assign dsh   = diff >>> c_avg;
  assign dext  = {{(ACC_W-SW-1){dsh[SW]}}, dsh};
  assign err_d = (c_pol ? -dext : dext) - c_off;

  assign inc  = err_q >>> p_gs_q;
  assign rinc = step_q >>> p_gr_q;
  assign mod  = ph_q ? c_ampl : c_amph;

`ifdef FOG_STEP_SAT_EN
  localparam logic signed [ACC_W:0] SMAX =
    {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SMIN =
    {2'b11, {(ACC_W-2){1'b0}}, 1'b1};
  logic signed [ACC_W:0] wide;
  logic                  sat;
  assign wide = {step_q[ACC_W-1], step_q}
              + {inc[ACC_W-1], inc};
  // Clamp the integrator to the symmetric signed range.
  always_comb begin
    step_nx = wide[ACC_W-1:0];
    sat     = 1'b0;
    if (wide > SMAX) begin
      step_nx = SMAX[ACC_W-1:0];
      sat     = 1'b1;
    end else if (wide < SMIN) begin
      step_nx = SMIN[ACC_W-1:0];
      sat     = 1'b1;
    end
  end
`else
  assign step_nx = step_q + inc;
`endif

  // Snapshot the configuration at the start of each H half.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      half_q <= '0; wait_q <= '0; avg_q <= '0;
      amph_q <= '0; ampl_q <= '0; pol_q <= 1'b0;
      off_q  <= '0; fb_q   <= 1'b0; cs_q <= '0;
      gs_q   <= '0; gr_q   <= '0;
    end else if (first_h) begin
      half_q <= i_half_cnt;   wait_q <= i_wait_cnt;
      avg_q  <= avg_cl;       amph_q <= i_amp_h;
      ampl_q <= i_amp_l;      pol_q  <= i_polarity;
      off_q  <= i_err_offset; fb_q   <= i_fb_on;
      cs_q   <= i_const_step; gs_q   <= i_gain_step;
      gr_q   <= i_gain_ramp;
    end
  end

  // Half-period timebase and per-half sample sums.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_q  <= 1'b0;
      ph_q   <= 1'b0;
      hcnt_q <= '0;
      sum_q  <= '0;
      sumh_q <= '0;
    end else begin
      run_q <= 1'b1;
      sum_q <= sum_d;
      if (last) begin
        hcnt_q <= '0;
        ph_q   <= ~ph_q;
        if (!ph_q) sumh_q <= sum_d;
      end else begin
        hcnt_q <= hcnt_q + 32'd1;
      end
    end
  end

  // Demodulated error and the period's loop settings at period end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q     <= '0;
      err_vld_q <= 1'b0;
      cfg_err_q <= 1'b0;
      p_fb_q    <= 1'b0;
      p_cs_q    <= '0;
      p_gs_q    <= '0;
      p_gr_q    <= '0;
    end else begin
      err_vld_q <= end_per && period_ok;
      if (end_per) begin
        cfg_err_q <= !period_ok;
        if (period_ok) err_q <= err_d;
        p_fb_q <= c_fb;
        p_cs_q <= c_cs;
        p_gs_q <= c_gs;
        p_gr_q <= c_gr;
      end
`ifdef FOG_STEP_SAT_EN
      if (err_vld_q && p_fb_q && sat) cfg_err_q <= 1'b1;
`endif
    end
  end

  // Step integrator one cycle after the error, ramp one after that.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      step_q    <= '0;
      ramp_q    <= '0;
      stp_vld_q <= 1'b0;
    end else begin
      stp_vld_q <= err_vld_q;
      if (err_vld_q) step_q <= p_fb_q ? step_nx : p_cs_q;
      if (stp_vld_q) ramp_q <= ramp_q + rinc;
    end
  end

  // DAC word: ramp MSBs plus the current modulation level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) dac_q <= '0;
    else       dac_q <= ramp_q[ACC_W-1 -: DAC_W] + mod;
  end

  assign o_dac     = dac_q;
  assign o_err     = err_q;
  assign o_err_vld = err_vld_q;
  assign o_step    = step_q;
  assign o_ramp    = ramp_q;
  assign o_cfg_err = cfg_err_q;

endmodule
